// File: rtl/idex_alu_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU.
// Decodes the ALU control line, forwards operands and flags load-use hazards.
module idex_alu_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [15:0]   id_imm16,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [4:0]    id_shamt,
   input  logic [5:0]    id_funct,
   input  logic [1:0]    id_aluop,
   input  logic          id_alusrc,
   input  logic          id_regdst,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic          id_memtoreg,
   input  logic          exmem_regwrite,
   input  logic [RW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_result,
   output logic          ex_valid,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_gin,
   output logic [DW-1:0] ex_store_data,
   output logic [RW-1:0] ex_wr_reg,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          ex_memtoreg,
   output logic          ex_illegal,
   output logic          load_use_stall
);

   localparam logic [2:0] GIN_AND = 3'b000;
   localparam logic [2:0] GIN_OR  = 3'b001;
   localparam logic [2:0] GIN_ADD = 3'b010;
   localparam logic [2:0] GIN_SUB = 3'b110;
   localparam logic [2:0] GIN_SLT = 3'b111;
   localparam logic [2:0] GIN_SLL = 3'b101;

   logic          valid_q,    valid_d;
   logic [DW-1:0] rs_data_q,  rs_data_d;
   logic [DW-1:0] rt_data_q,  rt_data_d;
   logic [DW-1:0] imm_q,      imm_d;
   logic [RW-1:0] rs_q,       rs_d;
   logic [RW-1:0] rt_q,       rt_d;
   logic [RW-1:0] wr_q,       wr_d;
   logic [4:0]    shamt_q,    shamt_d;
   logic [2:0]    gin_q,      gin_d;
   logic          alusrc_q,   alusrc_d;
   logic          sll_q,      sll_d;
   logic          regwrite_q, regwrite_d;
   logic          memread_q,  memread_d;
   logic          memwrite_q, memwrite_d;
   logic          memtoreg_q, memtoreg_d;
   logic          illegal_q,  illegal_d;

   logic [2:0]    dec_gin;
   logic          dec_ill;
   logic          dec_sll;
   logic [DW-1:0] dec_imm;
   logic [DW-1:0] rs_fwd;
   logic [DW-1:0] rt_fwd;
   logic          bubble;

   // ALU control line and immediate form for the instruction sitting in ID
   always_comb begin
      dec_gin = GIN_ADD;
      dec_ill = 1'b0;
      dec_sll = 1'b0;
      unique case (id_aluop)
         2'b00: dec_gin = GIN_ADD;
         2'b01: dec_gin = GIN_SUB;
         2'b11: dec_gin = GIN_OR;
         default: begin
            unique case (id_funct)
               6'b100000: dec_gin = GIN_ADD;
               6'b100010: dec_gin = GIN_SUB;
               6'b100100: dec_gin = GIN_AND;
               6'b100101: dec_gin = GIN_OR;
               6'b101010: dec_gin = GIN_SLT;
               6'b000000: begin
                  dec_gin = GIN_SLL;
                  dec_sll = 1'b1;
               end
               default: dec_ill = 1'b1;
            endcase
         end
      endcase
      if (id_aluop == 2'b11)
         dec_imm = {{(DW-16){1'b0}}, id_imm16};
      else
         dec_imm = {{(DW-16){id_imm16[15]}}, id_imm16};
   end

   // A lw still in EX whose target is read by ID must bubble one cycle
   assign load_use_stall = valid_q && memread_q && (wr_q != '0)
                           && id_valid
                           && ((wr_q == id_rs) || (wr_q == id_rt));

   assign bubble = flush || (!stall && load_use_stall);

   // Next-state: bubble, hold, or capture the ID instruction
   always_comb begin
      valid_d    = valid_q;
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      wr_d       = wr_q;
      shamt_d    = shamt_q;
      gin_d      = gin_q;
      alusrc_d   = alusrc_q;
      sll_d      = sll_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      memtoreg_d = memtoreg_q;
      illegal_d  = illegal_q;
      if (bubble) begin
         valid_d    = 1'b0;
         rs_data_d  = '0;
         rt_data_d  = '0;
         imm_d      = '0;
         rs_d       = '0;
         rt_d       = '0;
         wr_d       = '0;
         shamt_d    = '0;
         gin_d      = GIN_ADD;
         alusrc_d   = 1'b0;
         sll_d      = 1'b0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         illegal_d  = 1'b0;
      end else if (!stall) begin
         valid_d    = id_valid;
         rs_data_d  = id_rs_data;
         rt_data_d  = id_rt_data;
         imm_d      = dec_imm;
         rs_d       = id_rs;
         rt_d       = id_rt;
         wr_d       = id_regdst ? id_rd : id_rt;
         shamt_d    = id_shamt;
         gin_d      = dec_gin;
         alusrc_d   = id_alusrc;
         sll_d      = dec_sll;
         regwrite_d = id_regwrite && !dec_ill;
         memread_d  = id_memread;
         memwrite_d = id_memwrite;
         memtoreg_d = id_memtoreg;
         illegal_d  = id_valid && dec_ill;
      end
   end

   // Stage registers; reset lands in the bubble state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q    <= 1'b0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         wr_q       <= '0;
         shamt_q    <= '0;
         gin_q      <= GIN_ADD;
         alusrc_q   <= 1'b0;
         sll_q      <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         wr_q       <= wr_d;
         shamt_q    <= shamt_d;
         gin_q      <= gin_d;
         alusrc_q   <= alusrc_d;
         sll_q      <= sll_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
         illegal_q  <= illegal_d;
      end
   end

   // rs forwarding: EX/MEM beats MEM/WB, $0 is never forwarded
   always_comb begin
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_q))
         rs_fwd = exmem_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_q))
         rs_fwd = memwb_result;
      else
         rs_fwd = rs_data_q;
   end

   // rt forwarding: same priority as rs
   always_comb begin
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_q))
         rt_fwd = exmem_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_q))
         rt_fwd = memwb_result;
      else
         rt_fwd = rt_data_q;
   end

   // sll shifts rt by shamt, so both operands are swapped in
   always_comb begin
      if (sll_q) begin
         alu_a = rt_fwd;
         alu_b = {{(DW-5){1'b0}}, shamt_q};
      end else begin
         alu_a = rs_fwd;
         alu_b = alusrc_q ? imm_q : rt_fwd;
      end
   end

   assign alu_gin       = gin_q;
   assign ex_store_data = rt_fwd;
   assign ex_wr_reg     = wr_q;
   assign ex_valid      = valid_q;
   assign ex_regwrite   = valid_q && regwrite_q;
   assign ex_memread    = valid_q && memread_q;
   assign ex_memwrite   = valid_q && memwrite_q;
   assign ex_memtoreg   = valid_q && memtoreg_q;
   assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_idex_alu_stage.sv
// Bench for idex_alu_stage: directed plan items plus random traffic.
// A per-cycle prediction queue is drained by an independent monitor.
module tb_idex_alu_stage;

   typedef struct {
      logic        valid;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [15:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [1:0]  aluop;
      logic        alusrc;
      logic        regdst;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        memtoreg;
   } ins_t;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] res;
   } fw_t;

   typedef struct {
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [2:0]  gin;
      logic [4:0]  wr;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        mt;
      logic        ill;
      logic        lus;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   ins_t id_s;
   fw_t  em_s;
   fw_t  mw_s;
   logic stall_s = 1'b0;
   logic flush_s = 1'b0;
   logic reset_s = 1'b1;
   ins_t ex_m;
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   logic [5:0] fn_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                              6'h2a, 6'h00, 6'h3f, 6'h07};

   logic        ex_valid;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_gin;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_wr_reg;
   logic        ex_regwrite;
   logic        ex_memread;
   logic        ex_memwrite;
   logic        ex_memtoreg;
   logic        ex_illegal;
   logic        load_use_stall;

   idex_alu_stage #(.DW(32), .RW(5)) dut (
      .clk            (clk),
      .reset          (reset_s),
      .stall          (stall_s),
      .flush          (flush_s),
      .id_valid       (id_s.valid),
      .id_rs_data     (id_s.rs_data),
      .id_rt_data     (id_s.rt_data),
      .id_imm16       (id_s.imm),
      .id_rs          (id_s.rs),
      .id_rt          (id_s.rt),
      .id_rd          (id_s.rd),
      .id_shamt       (id_s.shamt),
      .id_funct       (id_s.funct),
      .id_aluop       (id_s.aluop),
      .id_alusrc      (id_s.alusrc),
      .id_regdst      (id_s.regdst),
      .id_regwrite    (id_s.regwrite),
      .id_memread     (id_s.memread),
      .id_memwrite    (id_s.memwrite),
      .id_memtoreg    (id_s.memtoreg),
      .exmem_regwrite (em_s.we),
      .exmem_rd       (em_s.rd),
      .exmem_result   (em_s.res),
      .memwb_regwrite (mw_s.we),
      .memwb_rd       (mw_s.rd),
      .memwb_result   (mw_s.res),
      .ex_valid       (ex_valid),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_gin        (alu_gin),
      .ex_store_data  (ex_store_data),
      .ex_wr_reg      (ex_wr_reg),
      .ex_regwrite    (ex_regwrite),
      .ex_memread     (ex_memread),
      .ex_memwrite    (ex_memwrite),
      .ex_memtoreg    (ex_memtoreg),
      .ex_illegal     (ex_illegal),
      .load_use_stall (load_use_stall)
   );

   function automatic ins_t bubble_ins();
      ins_t b;
      b = '{default: '0};
      return b;
   endfunction

   function automatic fw_t fw(input logic we, input logic [4:0] rd,
                              input logic [31:0] res);
      fw_t f;
      f.we = we;
      f.rd = rd;
      f.res = res;
      return f;
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] idx,
                                       input logic [31:0] v,
                                       input fw_t em, input fw_t mw);
      if (em.we && em.rd != 0 && em.rd == idx) return em.res;
      if (mw.we && mw.rd != 0 && mw.rd == idx) return mw.res;
      return v;
   endfunction

   // What the ALU should see for instruction e in EX, given live forwarding
   function automatic exp_t predict(input ins_t e, input fw_t em,
                                    input fw_t mw, input ins_t id);
      exp_t r;
      logic ill;
      logic sll;
      logic [31:0] imm;
      logic [31:0] rsv;
      logic [31:0] rtv;
      ill = 1'b0;
      sll = (e.aluop == 2'd2) && (e.funct == 6'd0);
      case (e.aluop)
         2'd0: r.gin = 3'b010;
         2'd1: r.gin = 3'b110;
         2'd3: r.gin = 3'b001;
         default:
            case (e.funct)
               6'h20: r.gin = 3'b010;
               6'h22: r.gin = 3'b110;
               6'h24: r.gin = 3'b000;
               6'h25: r.gin = 3'b001;
               6'h2a: r.gin = 3'b111;
               6'h00: r.gin = 3'b101;
               default: begin
                  r.gin = 3'b010;
                  ill = 1'b1;
               end
            endcase
      endcase
      if (e.aluop == 2'd3) imm = {16'h0, e.imm};
      else imm = {{16{e.imm[15]}}, e.imm};
      rsv = fwd(e.rs, e.rs_data, em, mw);
      rtv = fwd(e.rt, e.rt_data, em, mw);
      r.a = sll ? rtv : rsv;
      r.b = sll ? {27'h0, e.shamt} : (e.alusrc ? imm : rtv);
      r.sd = rtv;
      r.wr = e.regdst ? e.rd : e.rt;
      r.v = e.valid;
      r.rw = e.valid && e.regwrite && !ill;
      r.mr = e.valid && e.memread;
      r.mw = e.valid && e.memwrite;
      r.mt = e.valid && e.memtoreg;
      r.ill = e.valid && ill;
      r.lus = e.valid && e.memread && r.wr != 0 && id.valid
              && (r.wr == id.rs || r.wr == id.rt);
      return r;
   endfunction

   task automatic step(input ins_t i, input fw_t em, input fw_t mw,
                       input logic st, input logic fl, input logic rs);
      exp_t e;
      @(negedge clk);
      id_s = i;
      em_s = em;
      mw_s = mw;
      stall_s = st;
      flush_s = fl;
      reset_s = rs;
      if (rs) ex_m = bubble_ins();
      #1;
      e = predict(ex_m, em, mw, i);
      sb.push_back(e);
      @(posedge clk);
      if (rs || fl) ex_m = bubble_ins();
      else if (!st) ex_m = e.lus ? bubble_ins() : i;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
      end
   endtask

   // Monitor: compares DUT outputs with the oldest prediction each cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ex_valid", {31'h0, ex_valid}, {31'h0, e.v});
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
            chk("alu_gin", {29'h0, alu_gin}, {29'h0, e.gin});
            chk("store_data", ex_store_data, e.sd);
            chk("wr_reg", {27'h0, ex_wr_reg}, {27'h0, e.wr});
            chk("regwrite", {31'h0, ex_regwrite}, {31'h0, e.rw});
            chk("memread", {31'h0, ex_memread}, {31'h0, e.mr});
            chk("memwrite", {31'h0, ex_memwrite}, {31'h0, e.mw});
            chk("memtoreg", {31'h0, ex_memtoreg}, {31'h0, e.mt});
            chk("illegal", {31'h0, ex_illegal}, {31'h0, e.ill});
            chk("load_use", {31'h0, load_use_stall}, {31'h0, e.lus});
         end
      end
   end

   function automatic ins_t rtype(input logic [5:0] f, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [31:0] a,
                                  input logic [31:0] b);
      ins_t i;
      i = bubble_ins();
      i.valid = 1'b1;
      i.aluop = 2'd2;
      i.funct = f;
      i.rs = rs;
      i.rt = rt;
      i.rd = 5'd9;
      i.regdst = 1'b1;
      i.regwrite = 1'b1;
      i.rs_data = a;
      i.rt_data = b;
      return i;
   endfunction

   function automatic ins_t rand_ins();
      ins_t r;
      r.valid = ($urandom_range(0, 4) != 0);
      r.rs_data = $urandom;
      r.rt_data = $urandom;
      r.imm = 16'($urandom);
      r.rs = 5'($urandom_range(0, 7));
      r.rt = 5'($urandom_range(0, 7));
      r.rd = 5'($urandom_range(0, 7));
      r.shamt = 5'($urandom);
      r.funct = fn_tab[$urandom_range(0, 7)];
      r.aluop = 2'($urandom);
      r.alusrc = 1'($urandom);
      r.regdst = 1'($urandom);
      r.regwrite = 1'($urandom);
      r.memread = ($urandom_range(0, 2) == 0);
      r.memwrite = 1'($urandom);
      r.memtoreg = 1'($urandom);
      return r;
   endfunction

   initial begin
      ins_t i;
      ins_t lw;
      fw_t  z;
      z = fw(1'b0, 5'd0, 32'h0);
      id_s = bubble_ins();
      em_s = z;
      mw_s = z;
      ex_m = bubble_ins();
      step(bubble_ins(), z, z, 1'b0, 1'b0, 1'b1);
      step(bubble_ins(), z, z, 1'b0, 1'b0, 1'b1);
      // Reset mid-operation, including during a stall
      step(rtype(6'h22, 5'd1, 5'd2, 32'd9, 32'd3), z, z, 1'b0, 1'b0, 1'b0);
      step(rtype(6'h20, 5'd1, 5'd2, 32'd1, 32'd1), z, z, 1'b1, 1'b0, 1'b0);
      step(rtype(6'h20, 5'd1, 5'd2, 32'd1, 32'd1), z, z, 1'b1, 1'b0, 1'b1);
      i = rtype(6'h20, 5'd1, 5'd2, 32'd5, 32'd7);
      step(i, z, z, 1'b0, 1'b0, 1'b0);
      step(bubble_ins(), z, z, 1'b0, 1'b0, 1'b0);
      // addi with negative immediate, then ori
      i = bubble_ins();
      i.valid = 1'b1;
      i.alusrc = 1'b1;
      i.imm = 16'hFFFE;
      i.regwrite = 1'b1;
      step(i, z, z, 1'b0, 1'b0, 1'b0);
      i.aluop = 2'd3;
      i.imm = 16'h8001;
      step(i, z, z, 1'b0, 1'b0, 1'b0);
      step(bubble_ins(), z, z, 1'b0, 1'b0, 1'b0);
      // Forwarding priority on rs=3, stage held while sources vary
      step(rtype(6'h20, 5'd3, 5'd5, 32'h11, 32'h22), z, z, 1'b0, 1'b0, 1'b0);
      step(bubble_ins(), fw(1'b1, 5'd3, 32'hAA), fw(1'b1, 5'd3, 32'hBB),
           1'b1, 1'b0, 1'b0);
      step(bubble_ins(), fw(1'b0, 5'd3, 32'hAA), fw(1'b1, 5'd3, 32'hBB),
           1'b1, 1'b0, 1'b0);
      step(bubble_ins(), fw(1'b1, 5'd0, 32'hAA), fw(1'b1, 5'd0, 32'hBB),
           1'b1, 1'b0, 1'b0);
      step(rtype(6'h20, 5'd0, 5'd0, 32'h11, 32'h22),
           fw(1'b1, 5'd5, 32'hCC), z, 1'b0, 1'b0, 1'b0);
      step(bubble_ins(), fw(1'b1, 5'd0, 32'hAA), fw(1'b1, 5'd0, 32'hBB),
           1'b0, 1'b0, 1'b0);
      // Load-use: lw $4 then a reader of $4, plus a load to $0
      lw = bubble_ins();
      lw.valid = 1'b1;
      lw.alusrc = 1'b1;
      lw.rt = 5'd4;
      lw.regwrite = 1'b1;
      lw.memread = 1'b1;
      lw.memtoreg = 1'b1;
      lw.imm = 16'h0010;
      step(lw, z, z, 1'b0, 1'b0, 1'b0);
      i = rtype(6'h20, 5'd4, 5'd6, 32'd1, 32'd2);
      step(i, z, z, 1'b0, 1'b0, 1'b0);
      step(i, z, z, 1'b0, 1'b0, 1'b0);
      lw.rt = 5'd0;
      step(lw, z, z, 1'b0, 1'b0, 1'b0);
      step(rtype(6'h20, 5'd0, 5'd0, 32'd1, 32'd2), z, z, 1'b0, 1'b0, 1'b0);
      // sll and illegal funct
      i = rtype(6'h00, 5'd2, 5'd3, 32'd99, 32'd1);
      i.shamt = 5'd4;
      step(i, z, z, 1'b0, 1'b0, 1'b0);
      step(rtype(6'h3f, 5'd2, 5'd3, 32'd1, 32'd2), z, z, 1'b0, 1'b0, 1'b0);
      step(bubble_ins(), z, z, 1'b0, 1'b0, 1'b0);
      // Hold for three cycles, then flush together with stall
      step(rtype(6'h2a, 5'd1, 5'd2, 32'd3, 32'd8), z, z, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
         step(rand_ins(), z, z, 1'b1, 1'b0, 1'b0);
      step(rand_ins(), z, z, 1'b1, 1'b1, 1'b0);
      step(rand_ins(), z, z, 1'b1, 1'b0, 1'b0);
      // Random traffic
      for (int k = 0; k < 400; k++) begin
         step(rand_ins(),
              fw(1'($urandom), 5'($urandom_range(0, 7)), $urandom),
              fw(1'($urandom), 5'($urandom_range(0, 7)), $urandom),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 60) == 0));
      end
      repeat (3) @(negedge clk);
      #4;
      chk("drain", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
